rom_load_ctl: RTL and testbench

ROM_LOAD_CTL -- requirements
Module: rom_load_ctl

---
 rtl/rom_load_ctl.sv | 137 +++++++++++++
 tb/tb_rom_load_ctl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_load_ctl.sv
// Cartridge ROM loader: captures the HPS download into the 32 KiB ROM RAM, derives the
// mirror mask from the image size, then holds the core in reset briefly before releasing it.
module rom_load_ctl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [14:0] cpu_a,
    output logic        mem_we,
    output logic [14:0] mem_a,
    output logic [7:0]  mem_d,
    output logic        core_reset,
    output logic [16:0] rom_size,
    output logic [14:0] rom_mask,
    output logic        load_done,
    output logic        overflow,
    output logic        empty
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_FINISH = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;

    logic [2:0]  r_state;
    logic        r_dl_d;
    logic [3:0]  r_hold_cnt;
    logic [14:0] r_wr_a;

    logic        w_dl_rise;
    logic        w_dl_fall;
    logic        w_wr_valid;
    logic        w_addr_in_range;
    logic [16:0] w_wr_size;
    logic [16:0] w_size_m1;
    logic [16:0] w_s1;
    logic [16:0] w_s2;
    logic [16:0] w_s4;
    logic [16:0] w_s8;
    logic [14:0] w_mask;

    assign w_dl_rise       = ioctl_download & ~r_dl_d;
    assign w_dl_fall       = ~ioctl_download & r_dl_d;
    assign w_wr_valid      = ioctl_download & ioctl_wr;
    assign w_addr_in_range = (ioctl_addr[24:15] == 10'd0);
    assign w_wr_size       = {2'b00, ioctl_addr[14:0]} + 17'd1;

    // Smearing (size-1) rightwards yields (next power of two) - 1.
    assign w_size_m1 = rom_size - 17'd1;
    assign w_s1      = w_size_m1 | (w_size_m1 >> 1);
    assign w_s2      = w_s1 | (w_s1 >> 2);
    assign w_s4      = w_s2 | (w_s2 >> 4);
    assign w_s8      = w_s4 | (w_s4 >> 8);

    always_comb begin
        w_mask = 15'h7FFF;
        if (rom_size <= 17'd2048) begin
            w_mask = 15'h07FF;
        end else if (w_s8[16:15] == 2'b00) begin
            w_mask = w_s8[14:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_dl_d     <= 1'b0;
            r_hold_cnt <= 4'd0;
            r_wr_a     <= '0;
            mem_we     <= 1'b0;
            mem_d      <= '0;
            rom_size   <= '0;
            rom_mask   <= 15'h7FFF;
            load_done  <= 1'b0;
            overflow   <= 1'b0;
            empty      <= 1'b0;
        end else begin
            r_dl_d    <= ioctl_download;
            load_done <= 1'b0;
            mem_we    <= 1'b0;
            if (w_dl_rise) begin
                r_state    <= ST_LOAD;
                r_hold_cnt <= 4'd0;
                rom_size   <= '0;
                overflow   <= 1'b0;
                empty      <= 1'b0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (w_dl_fall) begin
                            r_state <= ST_FINISH;
                        end else if (w_wr_valid) begin
                            if (w_addr_in_range) begin
                                mem_we <= 1'b1;
                                r_wr_a <= ioctl_addr[14:0];
                                mem_d  <= ioctl_dout;
                                if (w_wr_size > rom_size) begin
                                    rom_size <= w_wr_size;
                                end
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                    ST_FINISH: begin
                        if (rom_size == 17'd0) begin
                            empty    <= 1'b1;
                            rom_mask <= 15'h7FFF;
                            r_state  <= ST_IDLE;
                        end else begin
                            rom_mask   <= w_mask;
                            r_hold_cnt <= 4'd0;
                            r_state    <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        r_hold_cnt <= r_hold_cnt + 4'd1;
                        if (r_hold_cnt == 4'hF) begin
                            r_state   <= ST_RUN;
                            load_done <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // The registered write address owns the bus only in the cycle the write is presented.
    assign mem_a      = mem_we ? r_wr_a : (cpu_a & rom_mask);
    assign core_reset = (r_state != ST_RUN);

endmodule

// File: tb/tb_rom_load_ctl.sv
// Directed bench for rom_load_ctl: table of download scenarios plus hand-written
// sequences for write latency, HOLD interruption and reset during LOAD.
module tb_rom_load_ctl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [14:0] cpu_a;
    logic        mem_we;
    logic [14:0] mem_a;
    logic [7:0]  mem_d;
    logic        core_reset;
    logic [16:0] rom_size;
    logic [14:0] rom_mask;
    logic        load_done;
    logic        overflow;
    logic        empty;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int ld_cnt = 0;
    int bad_cnt = 0;

    always #5 clk = ~clk;

    rom_load_ctl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .cpu_a         (cpu_a),
        .mem_we        (mem_we),
        .mem_a         (mem_a),
        .mem_d         (mem_d),
        .core_reset    (core_reset),
        .rom_size      (rom_size),
        .rom_mask      (rom_mask),
        .load_done     (load_done),
        .overflow      (overflow),
        .empty         (empty)
    );

    // Data byte written at address a is a[15:8]^a[7:0], so a leaked write above 32 KiB
    // lands with the wrong data for its wrapped address.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_we) begin
                wr_cnt++;
                if (mem_d !== ({1'b0, mem_a[14:8]} ^ mem_a[7:0])) bad_cnt++;
            end
            if (load_done) ld_cnt++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          n;
        int          base;
        logic [14:0] cpu;
        logic [16:0] size;
        logic [14:0] mask;
        logic        ovf;
        logic        emp;
        int          writes;
        logic        run;
        logic [14:0] mema;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string name);
        chk(name, {core_reset, mem_we, mem_d, rom_size, rom_mask, load_done, overflow, empty},
            {1'b1, 1'b0, 8'h00, 17'h0, 15'h7FFF, 3'b000});
    endtask

    // Rise, n consecutive writes from base, then drop download (caller is at the fall).
    task automatic do_download(input int n, input int base);
        logic [31:0] a;
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b0;
        step();
        for (int i = 0; i < n; i++) begin
            a          = base + i;
            ioctl_wr   = 1'b1;
            ioctl_addr = a[24:0];
            ioctl_dout = a[15:8] ^ a[7:0];
            step();
        end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
    endtask

    task automatic wait_run(output int fall_k);
        fall_k = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (!core_reset) begin
                fall_k = k;
                break;
            end
        end
    endtask

    initial begin
        int wr0, ld0, fk;

        tbl[0] = '{4096,  0,    15'h1ABC, 17'd4096,  15'h0FFF, 1'b0, 1'b0, 4096,  1'b1, 15'h0ABC};
        tbl[1] = '{2048,  0,    15'h1ABC, 17'd2048,  15'h07FF, 1'b0, 1'b0, 2048,  1'b1, 15'h02BC};
        tbl[2] = '{40000, 0,    15'h1ABC, 17'd32768, 15'h7FFF, 1'b1, 1'b0, 32768, 1'b1, 15'h1ABC};
        tbl[3] = '{0,     0,    15'h5555, 17'd0,     15'h7FFF, 1'b0, 1'b1, 0,     1'b0, 15'h5555};
        tbl[4] = '{100,   0,    15'h7FFF, 17'd100,   15'h07FF, 1'b0, 1'b0, 100,   1'b1, 15'h07FF};
        tbl[5] = '{1,     4096, 15'h7FFF, 17'd4097,  15'h1FFF, 1'b0, 1'b0, 1,     1'b1, 15'h1FFF};
        tbl[6] = '{1,     2047, 15'h0FFF, 17'd2048,  15'h07FF, 1'b0, 1'b0, 1,     1'b1, 15'h07FF};
        tbl[7] = '{1,     2048, 15'h7FFF, 17'd2049,  15'h0FFF, 1'b0, 1'b0, 1,     1'b1, 15'h0FFF};

        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        cpu_a          = '0;
        step();
        step();
        chk_reset_vals("reset_values");
        reset_n = 1'b1;
        step();

        // Strobes without an active download must be ignored.
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h10;
        ioctl_dout = 8'h10;
        step(); step(); step();
        chk("wr_no_dl_we", mem_we, 0);
        chk("wr_no_dl_size", rom_size, 0);
        ioctl_wr = 1'b0;

        // One-cycle write latency.
        ioctl_download = 1'b1;
        step();
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h123;
        ioctl_dout = 8'h22;
        @(negedge clk);
        chk("wr_latency_pre", mem_we, 0);
        @(posedge clk);
        #1;
        ioctl_wr = 1'b0;
        chk("wr_latency_we", mem_we, 1);
        chk("wr_latency_a", mem_a, 15'h123);
        chk("wr_latency_d", mem_d, 8'h22);
        chk("wr_latency_size", rom_size, 17'h124);
        step();
        chk("wr_pulse_end", mem_we, 0);
        ioctl_download = 1'b0;
        for (int k = 0; k < 25; k++) step();

        for (int v = 0; v < 8; v++) begin
            wr0 = wr_cnt;
            ld0 = ld_cnt;
            do_download(tbl[v].n, tbl[v].base);
            wait_run(fk);
            chk($sformatf("v%0d_rst_fall_cycle", v), fk, tbl[v].run ? 18 : 0);
            step(); step();
            chk($sformatf("v%0d_load_done_pulses", v), ld_cnt - ld0, tbl[v].run ? 1 : 0);
            chk($sformatf("v%0d_writes", v), wr_cnt - wr0, tbl[v].writes);
            chk($sformatf("v%0d_bad_data", v), bad_cnt, 0);
            chk($sformatf("v%0d_rom_size", v), rom_size, tbl[v].size);
            chk($sformatf("v%0d_rom_mask", v), rom_mask, tbl[v].mask);
            chk($sformatf("v%0d_overflow", v), overflow, tbl[v].ovf);
            chk($sformatf("v%0d_empty", v), empty, tbl[v].emp);
            chk($sformatf("v%0d_core_reset", v), core_reset, !tbl[v].run);
            cpu_a = tbl[v].cpu;
            #1;
            chk($sformatf("v%0d_mem_a", v), mem_a, tbl[v].mema);
            chk($sformatf("v%0d_mem_we_idle", v), mem_we, 0);
            step();
        end

        // New download rising during HOLD cycle 8.
        ld0 = ld_cnt;
        do_download(300, 0);
        for (int k = 1; k <= 9; k++) step();
        chk("hold8_core_reset", core_reset, 1);
        chk("hold8_size_before", rom_size, 300);
        ioctl_download = 1'b1;
        step();
        chk("hold_rise_size_clear", rom_size, 0);
        chk("hold_rise_core_reset", core_reset, 1);
        fk = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (!core_reset) fk++;
        end
        chk("hold_rise_stays_reset", fk, 0);
        ioctl_download = 1'b0;
        for (int k = 0; k < 25; k++) step();
        chk("hold_rise_empty", empty, 1);
        chk("hold_rise_core_reset_end", core_reset, 1);
        chk("hold_rise_no_load_done", ld_cnt - ld0, 0);

        // Reset asserted mid-LOAD.
        do_download(50, 0);
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b1;
        reset_n        = 1'b0;
        #1;
        chk_reset_vals("midload_reset_async");
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        step(); step(); step();
        reset_n = 1'b1;
        ld0 = ld_cnt;
        for (int k = 0; k < 10; k++) step();
        chk_reset_vals("midload_after_release");
        chk("midload_no_load_done", ld_cnt - ld0, 0);

        do_download(16, 0);
        wait_run(fk);
        chk("recover_rst_fall_cycle", fk, 18);
        chk("recover_rom_size", rom_size, 16);
        chk("recover_rom_mask", rom_mask, 15'h07FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
